bcd_ndigit_conv: RTL

Sequential binary-to-BCD converter, parametrised in input width and digit count, using the shift-and-add-3 (double-dabble) method with one bit per clock. It feeds the multiplexed seven-segment display path on the CoolRunner-II board. It adds four features:
- start/busy/done handshake;
- optional free-running mode;
- overflow saturation;
- a leading-zero blanking mask for the display driver.

---
 rtl/bcd_ndigit_conv_if.sv | 24 ++
 rtl/bcd_ndigit_conv.sv | 110 +++++++++++
 2 files changed

// File: rtl/bcd_ndigit_conv_if.sv
// Handshake and result bundle between a requester and the bcd_ndigit_conv converter.
// The master side supplies operands; the slave side (the converter) returns results.
interface bcd_ndigit_conv_if #(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
);
   logic [WIDTH-1:0]    value;
   logic                start;
   logic                busy;
   logic                done;
   logic [4*DIGITS-1:0] bcd;
   logic [DIGITS-1:0]   blank;
   logic                overflow;

   modport master (
      output value, start,
      input  busy, done, bcd, blank, overflow
   );

   modport slave (
      input  value, start,
      output busy, done, bcd, blank, overflow
   );
endinterface

// File: rtl/bcd_ndigit_conv.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with
// start/busy/done handshake, optional free-running mode, saturation and leading-zero mask.
module bcd_ndigit_conv #(
   parameter int WIDTH      = 14,
   parameter int DIGITS     = 4,
   parameter int CONTINUOUS = 0
) (
   input logic              clk,
   input logic              rst,
   bcd_ndigit_conv_if.slave bus
);

   localparam int BCDW = 4 * DIGITS;
   localparam int SHW  = BCDW + WIDTH;
   localparam int CW   = $clog2(WIDTH + 1);

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0]       LIMIT       = pow10(DIGITS);
   localparam logic [BCDW-1:0]   NINES       = {DIGITS{4'h9}};
   localparam logic [DIGITS-1:0] BLANK_RESET = {DIGITS{1'b1}} ^ DIGITS'(1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state;
   state_t            stateNext;
   logic [SHW-1:0]    shreg;
   logic [SHW-1:0]    adjusted;
   logic [SHW-1:0]    shifted;
   logic [CW-1:0]     count;
   logic              ovfLatched;
   logic              accept;
   logic              lastIter;
   logic [BCDW-1:0]   resultBcd;
   logic [DIGITS-1:0] resultBlank;
   logic              allZero;

   assign accept   = (state == IDLE) && ((CONTINUOUS != 0) || bus.start);
   assign lastIter = (state == SHIFT) && (count == CW'(1));
   assign bus.busy = (state == SHIFT);

   // One double-dabble step: add 3 to every digit nibble >= 5, then shift the whole register left.
   always_comb begin
      adjusted = shreg;
      for (int d = 0; d < DIGITS; d++) begin
         if (shreg[WIDTH+4*d +: 4] >= 4'd5)
            adjusted[WIDTH+4*d +: 4] = shreg[WIDTH+4*d +: 4] + 4'd3;
      end
      shifted = adjusted << 1;
   end

   // Final result after the last step; a digit is blanked only if it and every higher digit are zero.
   always_comb begin
      resultBcd   = ovfLatched ? NINES : shifted[SHW-1 -: BCDW];
      resultBlank = '0;
      allZero     = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         allZero        = allZero & (resultBcd[4*i +: 4] == 4'd0);
         resultBlank[i] = allZero;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (accept) stateNext = SHIFT;
         SHIFT:   if (count == CW'(1)) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Outputs only move on the final step so the display never shows a partial conversion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg        <= '0;
         count        <= '0;
         ovfLatched   <= 1'b0;
         bus.bcd      <= '0;
         bus.blank    <= BLANK_RESET;
         bus.overflow <= 1'b0;
         bus.done     <= 1'b0;
      end else begin
         bus.done <= lastIter;
         if (accept) begin
            shreg      <= SHW'(bus.value);
            count      <= CW'(WIDTH);
            ovfLatched <= (64'(bus.value) >= LIMIT);
         end else if (state == SHIFT) begin
            shreg <= shifted;
            count <= count - CW'(1);
            if (lastIter) begin
               bus.bcd      <= resultBcd;
               bus.blank    <= resultBlank;
               bus.overflow <= ovfLatched;
            end
         end
      end
   end

endmodule
